// File: rtl/cpu_pkg.sv
// Shared CPU constants and the 2:1 word mux used by the fetch next-PC select.
package cpu_pkg;

  localparam logic [31:0] NOP = 32'h8B1F03FF;  // ADD XZR,XZR,XZR
  localparam int unsigned PC_INC = 4;
  localparam int unsigned BUBBLE_CNT_WIDTH = 16;
  localparam int unsigned WORD_WIDTH = 64;

  // Returns b when sel is high, otherwise a.
  function automatic logic [WORD_WIDTH-1:0] word_mux2(input logic sel,
                                                      input logic [WORD_WIDTH-1:0] a,
                                                      input logic [WORD_WIDTH-1:0] b);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Enabled register with synchronous active-high reset to a parameterised value.
module pipe_reg #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID register and saturating bubble counter.
// Define BRANCH_DELAY_SLOT_EN to keep the instruction after a taken branch as a delay slot.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        br_taken,
  input  logic [DATA_WIDTH-1:0]       br_target,
  output logic [DATA_WIDTH-1:0]       imem_addr,
  input  logic [INSTR_WIDTH-1:0]      imem_instr,
  output logic                        ifid_valid,
  output logic [DATA_WIDTH-1:0]       ifid_pc,
  output logic [INSTR_WIDTH-1:0]      ifid_instr,
  output logic [BUBBLE_CNT_WIDTH-1:0] bubble_cnt
);

  localparam logic [INSTR_WIDTH-1:0] NopWord = INSTR_WIDTH'(NOP);

  logic [DATA_WIDTH-1:0]  pc_q;
  logic [DATA_WIDTH-1:0]  pc_plus4;
  logic [DATA_WIDTH-1:0]  br_target_aligned;
  logic [DATA_WIDTH-1:0]  pc_next;
  logic [INSTR_WIDTH-1:0] instr_next;
  logic                   redirect;
  logic                   squash;
  logic                   advance;

  assign advance  = ~stall;
  // A stalled branch is ignored; decode re-presents it once the stall clears.
  assign redirect = br_taken & ~stall;

`ifdef BRANCH_DELAY_SLOT_EN
  assign squash = 1'b0;
`else
  assign squash = redirect;
`endif

  assign pc_plus4          = pc_q + DATA_WIDTH'(PC_INC);
  assign br_target_aligned = {br_target[DATA_WIDTH-1:2], 2'b00};
  assign pc_next = DATA_WIDTH'(word_mux2(redirect, WORD_WIDTH'(pc_plus4),
                                         WORD_WIDTH'(br_target_aligned)));
  assign instr_next = squash ? NopWord : imem_instr;

  pipe_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_VAL  (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (advance),
    .d     (pc_next),
    .q     (pc_q)
  );

  pipe_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_VAL  ('0)
  ) u_ifid_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (advance),
    .d     (pc_q),
    .q     (ifid_pc)
  );

  pipe_reg #(
    .DATA_WIDTH (INSTR_WIDTH),
    .RESET_VAL  (NopWord)
  ) u_ifid_instr_reg (
    .clk   (clk),
    .reset (reset),
    .en    (advance),
    .d     (instr_next),
    .q     (ifid_instr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_valid <= 1'b0;
      bubble_cnt <= '0;
    end else begin
      if (advance) begin
        ifid_valid <= ~squash;
      end
      if ((stall || squash) && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

  assign imem_addr = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; a monitor checks each queued expectation after its edge.
module tb_fetch_stage;

  localparam logic [63:0] RST_PC = 64'h100;
  localparam logic [31:0] NOP_W  = 32'h8B1F03FF;

  typedef struct {
    logic [63:0] addr;
    logic        valid;
    logic [63:0] pc;
    logic [15:0] bub;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [63:0] br_target = '0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic [15:0] bubble_cnt;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  assign imem_instr = mem(imem_addr);

  fetch_stage #(
    .DATA_WIDTH  (64),
    .INSTR_WIDTH (32),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .ifid_valid (ifid_valid),
    .ifid_pc    (ifid_pc),
    .ifid_instr (ifid_instr),
    .bubble_cnt (bubble_cnt)
  );

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents fresh IF state after every edge; check it mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] ei;
      e  = exp_q.pop_front();
      ei = e.valid ? mem(e.pc) : NOP_W;
      cmp("imem_addr", imem_addr, e.addr);
      cmp("ifid_valid", 64'(ifid_valid), 64'(e.valid));
      cmp("ifid_pc", ifid_pc, e.pc);
      cmp("ifid_instr", 64'(ifid_instr), 64'(ei));
      cmp("bubble_cnt", 64'(bubble_cnt), 64'(e.bub));
    end
  end

  // Apply inputs for one edge and queue the hand-computed state expected after it.
  task automatic cyc(input logic rst, input logic st, input logic br, input logic [63:0] tgt,
                     input logic chk, input logic [63:0] e_addr, input logic e_valid,
                     input logic [63:0] e_pc, input logic [15:0] e_bub);
    exp_t e;
    reset = rst; stall = st; br_taken = br; br_target = tgt;
    @(posedge clk);
    if (chk) begin
      e.addr = e_addr; e.valid = e_valid; e.pc = e_pc; e.bub = e_bub;
      exp_q.push_back(e);
    end
    #1;
  endtask

  initial begin
    // Reset, then sequential fetch from RESET_PC.
    cyc(1, 0, 0, 0, 1, 64'h100, 0, 64'h0, 16'd0);
    cyc(0, 0, 0, 0, 1, 64'h104, 1, 64'h100, 16'd0);
    cyc(0, 0, 0, 0, 1, 64'h108, 1, 64'h104, 16'd0);
    // Three stall cycles hold PC and IF/ID.
    cyc(0, 1, 0, 0, 1, 64'h108, 1, 64'h104, 16'd1);
    cyc(0, 1, 0, 0, 1, 64'h108, 1, 64'h104, 16'd2);
    cyc(0, 1, 0, 0, 1, 64'h108, 1, 64'h104, 16'd3);
    cyc(0, 0, 0, 0, 1, 64'h10C, 1, 64'h108, 16'd3);
`ifdef BRANCH_DELAY_SLOT_EN
    cyc(0, 0, 1, 64'h203, 1, 64'h200, 1, 64'h10C, 16'd3);
    cyc(0, 0, 0, 0, 1, 64'h204, 1, 64'h200, 16'd3);
    // stall and br_taken together: stall only.
    cyc(0, 1, 1, 64'h400, 1, 64'h204, 1, 64'h200, 16'd4);
    cyc(0, 0, 1, 64'h400, 1, 64'h400, 1, 64'h204, 16'd4);
    cyc(0, 0, 0, 0, 1, 64'h404, 1, 64'h400, 16'd4);
    cyc(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h404, 16'd4);
    cyc(0, 0, 0, 0, 1, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 16'd4);
    cyc(0, 0, 0, 0, 1, 64'h4, 1, 64'h0, 16'd4);
`else
    cyc(0, 0, 1, 64'h203, 1, 64'h200, 0, 64'h10C, 16'd4);
    cyc(0, 0, 0, 0, 1, 64'h204, 1, 64'h200, 16'd4);
    cyc(0, 1, 1, 64'h400, 1, 64'h204, 1, 64'h200, 16'd5);
    cyc(0, 0, 1, 64'h400, 1, 64'h400, 0, 64'h204, 16'd6);
    cyc(0, 0, 0, 0, 1, 64'h404, 1, 64'h400, 16'd6);
    cyc(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h404, 16'd7);
    cyc(0, 0, 0, 0, 1, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 16'd7);
    cyc(0, 0, 0, 0, 1, 64'h4, 1, 64'h0, 16'd7);
`endif
    // Reset during a redirect wins.
    cyc(1, 0, 1, 64'h800, 1, 64'h100, 0, 64'h0, 16'd0);
    cyc(0, 0, 0, 0, 1, 64'h104, 1, 64'h100, 16'd0);
    // Long stall drives the counter into saturation.
    for (int i = 1; i <= 70000; i++) begin
      cyc(0, 1, 0, 0, (i == 65534 || i == 65535 || i == 65536 || i == 70000),
          64'h104, 1, 64'h100, (i >= 65535) ? 16'hFFFF : 16'(i));
    end
    cyc(0, 0, 0, 0, 1, 64'h108, 1, 64'h104, 16'hFFFF);
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
